// File: rtl/enable_sw_debounce.sv
// Slide-switch conditioner: 2-flop sync + per-bit counter debounce, 1-cycle toggle strobes.
// Latency 1+DEBOUNCE_CYCLES edges from the capturing edge; no backpressure, outputs always valid.
module enable_sw_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic [3:0] SW_raw,
   output logic [3:0] Enable_SW,
   output logic [3:0] SW_Edge,
   output logic       Mode_Change
);

   typedef enum logic {ST_STABLE, ST_PENDING} state_t;

   localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [3:0]  r_s1;
   logic [3:0]  r_s2;
   logic [3:0]  r_en;
   logic [3:0]  r_edge;
   logic        r_mode;
   state_t      r_state [4];
   logic [15:0] r_cnt   [4];
   logic [3:0]  w_accept;

   // A channel accepts when its new level has survived the full count.
   always_comb begin
      w_accept = '0;
      for (int i = 0; i < 4; i++) begin
         w_accept[i] = (r_state[i] == ST_PENDING) && (r_s2[i] != r_en[i]) && (r_cnt[i] == LAST);
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_en   <= '0;
         r_edge <= '0;
         r_mode <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_state[i] <= ST_STABLE;
            r_cnt[i]   <= '0;
         end
      end else begin
         r_s1   <= SW_raw;
         r_s2   <= r_s1;
         r_edge <= w_accept;
         r_mode <= |w_accept;
         for (int i = 0; i < 4; i++) begin
            case (r_state[i])
               ST_STABLE: begin
                  if (r_s2[i] != r_en[i]) begin
                     r_state[i] <= ST_PENDING;
                     r_cnt[i]   <= 16'd1;
                  end
               end
               ST_PENDING: begin
                  if (r_s2[i] == r_en[i]) begin
                     r_state[i] <= ST_STABLE;
                     r_cnt[i]   <= '0;
                  end else if (w_accept[i]) begin
                     r_en[i]    <= r_s2[i];
                     r_state[i] <= ST_STABLE;
                     r_cnt[i]   <= '0;
                  end else begin
                     r_cnt[i]   <= r_cnt[i] + 16'd1;
                  end
               end
               default: begin
                  r_state[i] <= ST_STABLE;
                  r_cnt[i]   <= '0;
               end
            endcase
         end
      end
   end

   assign Enable_SW   = r_en;
   assign SW_Edge     = r_edge;
   assign Mode_Change = r_mode;

endmodule

// File: tb/tb_enable_sw_debounce.sv
// Bench for enable_sw_debounce at DEBOUNCE_CYCLES=4: directed scenarios plus random switching.
// A window-of-samples reference model is compared against every output on every edge.
module tb_enable_sw_debounce;

   localparam int D = 4;

   logic       sysclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic [3:0] SW_raw = 4'h0;
   logic [3:0] Enable_SW;
   logic [3:0] SW_Edge;
   logic       Mode_Change;

   int checks = 0;
   int errors = 0;

   logic [3:0] m_s1, m_s2, m_en, m_edge;
   bit         hist [4][$];
   int         n_e2, n_mode;
   bit         en0_seen;

   enable_sw_debounce #(.DEBOUNCE_CYCLES(D)) dut (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .SW_raw      (SW_raw),
      .Enable_SW   (Enable_SW),
      .SW_Edge     (SW_Edge),
      .Mode_Change (Mode_Change)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_s1 = '0; m_s2 = '0; m_en = '0; m_edge = '0;
      for (int i = 0; i < 4; i++) hist[i].delete();
   endtask

   // A level is accepted once the last D synchronised samples all disagree with the output.
   task automatic model_edge();
      bit all_diff;
      m_edge = '0;
      for (int i = 0; i < 4; i++) begin
         hist[i].push_back(m_s2[i]);
         if (hist[i].size() > D) void'(hist[i].pop_front());
         if (hist[i].size() == D) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) if (hist[i][k] == m_en[i]) all_diff = 1'b0;
            if (all_diff) begin
               m_en[i]   = ~m_en[i];
               m_edge[i] = 1'b1;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = SW_raw;
   endtask

   task automatic tick();
      @(posedge sysclk);
      if (rst_n) model_edge();
      #1;
      chk("en", {12'd0, Enable_SW}, {12'd0, m_en});
      chk("edge", {12'd0, SW_Edge}, {12'd0, m_edge});
      chk("mode", {15'd0, Mode_Change}, {15'd0, |m_edge});
      if (SW_Edge[2]) n_e2++;
      if (Mode_Change) n_mode++;
      if (Enable_SW[0]) en0_seen = 1'b1;
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      model_clear();
      #1;
      chk("rst_async_en", {12'd0, Enable_SW}, 16'h0);
      chk("rst_async_edge", {12'd0, SW_Edge}, 16'h0);
      chk("rst_async_mode", {15'd0, Mode_Change}, 16'h0);
   endtask

   task automatic do_reset(input logic [3:0] sw);
      SW_raw = sw;
      assert_reset();
      tick();
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
   endtask

   initial begin
      model_clear();
      // Reset held with all switches high, then release.
      SW_raw = 4'hF;
      assert_reset();
      repeat (3) tick();
      chk("rst_hold_en", {12'd0, Enable_SW}, 16'h0);
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 5) chk("rst_e4_en", {12'd0, Enable_SW}, 16'h0);
         if (k == 6) begin
            chk("rst_e5_en", {12'd0, Enable_SW}, 16'hF);
            chk("rst_e5_edge", {12'd0, SW_Edge}, 16'hF);
            chk("rst_e5_mode", {15'd0, Mode_Change}, 16'h1);
         end
         if (k == 7) chk("rst_e6_mode", {15'd0, Mode_Change}, 16'h0);
      end

      // Fall of the square switch.
      SW_raw = 4'h7;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 5) chk("fall_e4_en", {12'd0, Enable_SW}, 16'hF);
         if (k == 6) begin
            chk("fall_e5_en", {12'd0, Enable_SW}, 16'h7);
            chk("fall_e5_edge", {12'd0, SW_Edge}, 16'h8);
         end
         if (k == 7) chk("fall_e6_edge", {12'd0, SW_Edge}, 16'h0);
      end

      // Clean rise on sine.
      do_reset(4'h0);
      SW_raw = 4'h1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 6) begin
            chk("rise_e5_en", {12'd0, Enable_SW}, 16'h1);
            chk("rise_e5_edge", {12'd0, SW_Edge}, 16'h1);
         end
         if (k == 7) chk("rise_e6_edge", {12'd0, SW_Edge}, 16'h0);
      end

      // Bounce on triangle: 1,1,1,0 then held 1.
      do_reset(4'h0);
      n_e2 = 0;
      for (int j = 0; j < 14; j++) begin
         SW_raw[2] = (j != 3);
         tick();
         if (j == 8) chk("bnc_pre_en2", {15'd0, Enable_SW[2]}, 16'h0);
         if (j == 9) chk("bnc_en2", {15'd0, Enable_SW[2]}, 16'h1);
      end
      chk("bnc_pulses", 16'(n_e2), 16'd1);

      // Saw and square together while sine chatters every 2 cycles.
      do_reset(4'h0);
      n_mode   = 0;
      en0_seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         SW_raw[1] = 1'b1;
         SW_raw[3] = 1'b1;
         SW_raw[0] = ((k / 2) % 2) == 0;
         tick();
         if (k == 5) begin
            chk("sim_en", {12'd0, Enable_SW}, 16'hA);
            chk("sim_edge", {12'd0, SW_Edge}, 16'hA);
         end
      end
      chk("sim_mode_pulses", 16'(n_mode), 16'd1);
      chk("sim_en0_quiet", {15'd0, en0_seen}, 16'h0);

      // Reset in the middle of a pending count.
      do_reset(4'h0);
      SW_raw = 4'h1;
      repeat (4) tick();
      chk("rmc_pre_en", {12'd0, Enable_SW}, 16'h0);
      assert_reset();
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 5) chk("rmc_e4_en", {12'd0, Enable_SW}, 16'h0);
         if (k == 6) chk("rmc_e5_en", {12'd0, Enable_SW}, 16'h1);
      end

      // Random bouncy switching with occasional resets.
      for (int n = 0; n < 4000; n++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r == 0) SW_raw = 4'($urandom);
         else if (r < 4) SW_raw[$urandom_range(0, 3)] = ~SW_raw[$urandom_range(0, 3)];
         if ($urandom_range(0, 499) == 0) begin
            assert_reset();
            tick();
            rst_n = 1'b1;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
